// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM encodings for the UART controller.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_ACTIVE  = 5;

    localparam int CT_ENABLE  = 0;
    localparam int CT_RX_IE   = 1;
    localparam int CT_TX_IE   = 2;
    localparam int CT_CLR_OVR = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head word; push on full succeeds only with a same-cycle pop.
// Pointers wrap modulo DEPTH (power of two); a separate count tracks occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart.sv
// 8N1 serial transmitter/receiver; one transmit byte accepted per we while idle, rx_done pulses per good frame.
// en gates only the start of new frames; frames already in flight always complete.
module uart
    import uart_pkg::*;
#(
    parameter int MAIN_FREQUENCY = 100000000,
    parameter int BAUD           = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    input  logic       we,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done
);
    localparam int CLKS = MAIN_FREQUENCY / BAUD;
    localparam int CW   = (CLKS > 2) ? $clog2(CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS / 2 - 1);

    ser_state_t    tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n;

    ser_state_t    rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_meta, rx_sync;

    assign tx       = tx_line;
    assign tx_busy  = (tx_state != SER_IDLE);
    assign data_out = rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= SER_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
            rx_state <= SER_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
        end
    end

    // tx_line is registered, so each bit holds for exactly CLKS cycles.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_done    = 1'b0;
        case (tx_state)
            SER_IDLE: begin
                tx_line_n = 1'b1;
                if (en && we) begin
                    tx_shift_n = data_in;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b0;
                    tx_state_n = SER_START;
                end
            end
            SER_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = SER_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            SER_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = SER_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            default: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_done    = 1'b1;
                    tx_state_n = SER_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
        endcase
    end

    // Start bit is re-checked at mid-bit so glitches are rejected; later samples land mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        case (rx_state)
            SER_IDLE: begin
                if (en && !rx_sync) begin
                    rx_cnt_n   = '0;
                    rx_state_n = SER_START;
                end
            end
            SER_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? SER_IDLE : SER_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            SER_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = SER_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            default: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_done    = rx_sync;
                    rx_state_n = SER_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_ctrl.sv
// Register-mapped UART controller: TX/RX FIFOs around the serial core, DATA/STATUS/CTRL registers, level irq.
// rdata is valid the cycle after rd; full-FIFO writes and full-FIFO receives are dropped, never stalled.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int MAIN_FREQUENCY = 100000000,
    parameter int BAUD           = 115200,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);
    tx_state_t  tx_state, tx_state_n;
    logic       enable, rx_ie, tx_ie, rx_overrun;
    logic [7:0] tx_head, rx_head, uart_dout, status;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_pop;
    logic       uart_we, uart_busy, uart_done, uart_rx_done;
    logic       ctrl_wr;

    assign tx_push = wr && (addr == ADDR_DATA);
    assign rx_pop  = rd && (addr == ADDR_DATA);
    assign ctrl_wr = wr && (addr == ADDR_CTRL);
    assign irq     = (rx_ie && !rx_empty) || (tx_ie && tx_empty);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_done),
        .pop   (rx_pop),
        .din   (uart_dout),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart #(.MAIN_FREQUENCY(MAIN_FREQUENCY), .BAUD(BAUD)) u_uart (
        .clk      (clk),
        .rst      (rst),
        .en       (enable),
        .data_in  (tx_head),
        .we       (uart_we),
        .tx_busy  (uart_busy),
        .tx_done  (uart_done),
        .tx       (tx),
        .rx       (rx),
        .data_out (uart_dout),
        .rx_done  (uart_rx_done)
    );

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_n;
    end

    // The head byte is only popped once the core has latched it (tx_busy seen).
    always_comb begin
        tx_state_n = tx_state;
        uart_we    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: if (enable && !tx_empty) tx_state_n = TX_LOAD;
            TX_LOAD: begin
                uart_we = 1'b1;
                if (uart_busy) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_WAIT;
                end
            end
            TX_WAIT: if (uart_done) tx_state_n = TX_IDLE;
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_TX_ACTIVE]  = (tx_state != TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable     <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
            rx_overrun <= 1'b0;
            rdata      <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= wdata[CT_ENABLE];
                rx_ie  <= wdata[CT_RX_IE];
                tx_ie  <= wdata[CT_TX_IE];
            end
            // A same-cycle DATA read frees a slot, so the incoming byte is not lost then.
            if (uart_rx_done && rx_full && !rx_pop)  rx_overrun <= 1'b1;
            else if (ctrl_wr && wdata[CT_CLR_OVR])    rx_overrun <= 1'b0;
            if (rd) begin
                case (addr)
                    ADDR_DATA:   rdata <= rx_empty ? 8'h00 : rx_head;
                    ADDR_STATUS: rdata <= status;
                    ADDR_CTRL:   rdata <= {5'b0, tx_ie, rx_ie, enable};
                    default:     rdata <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Randomized register/serial stimulus against a queue-based model of the controller's FIFOs and flags.
module tb_uart_ctrl;
    localparam int MF    = 1600000;
    localparam int BD    = 100000;
    localparam int CLKS  = MF / BD;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line, tx, wr, rd, irq;
    logic [1:0] addr;
    logic [7:0] wdata, rdata;
    logic       rx_drv   = 1'b1;
    logic       loopback = 1'b0;
    logic       mon_on   = 1'b0;

    assign rx_line = loopback ? tx : rx_drv;

    uart_ctrl #(.MAIN_FREQUENCY(MF), .BAUD(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx_line),
        .tx    (tx),
        .addr  (addr),
        .wr    (wr),
        .rd    (rd),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] mon_q[$];
    logic       ovr_m  = 1'b0;
    logic [2:0] ctrl_m = 3'b000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = (txq.size() == DEPTH);
        s[1] = (txq.size() == 0);
        s[2] = (rxq.size() == DEPTH);
        s[3] = (rxq.size() == 0);
        s[4] = ovr_m;
        return s;
    endfunction

    function automatic logic exp_irq();
        return (ctrl_m[1] && rxq.size() != 0) || (ctrl_m[2] && txq.size() == 0);
    endfunction

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d  = rdata;
    endtask

    task automatic host_ctrl(input logic [7:0] d);
        ctrl_m = d[2:0];
        if (d[3]) ovr_m = 1'b0;
        reg_write(2'd2, d);
    endtask

    task automatic host_tx(input logic [7:0] d);
        if (txq.size() < DEPTH) txq.push_back(d);
        reg_write(2'd0, d);
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        reg_read(2'd1, v);
        check(tag, v, exp_status());
    endtask

    task automatic check_rx_read(input string tag);
        logic [7:0] v, e;
        e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        reg_read(2'd0, v);
        check(tag, v, e);
    endtask

    task automatic rx_send(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (CLKS) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        if (ctrl_m[0]) begin
            if (rxq.size() < DEPTH) rxq.push_back(b);
            else                    ovr_m = 1'b1;
        end
    endtask

    // Every byte still queued in the TX model must appear on the line, in order.
    task automatic wait_tx(input string tag);
        int n, cyc;
        n = txq.size();
        cyc = 0;
        while (mon_q.size() < n && cyc < (n + 1) * 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_count"}, mon_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (mon_q.size() != 0) check({tag, "_byte"}, mon_q.pop_front(), txq[i]);
        end
        txq.delete();
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_tx_low(output int cyc);
        cyc = 0;
        while (tx !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("tx_start_seen", tx, 1'b0);
    endtask

    initial begin : tx_monitor
        logic [7:0] b;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                repeat (CLKS / 2 - 1) @(negedge clk);
                check("tx_start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLKS) @(negedge clk);
                check("tx_stop_bit", tx, 1'b1);
                mon_q.push_back(b);
            end
        end
    end

    initial begin : main
        logic [7:0] v;
        int         cyc, n, m, zeros;
        addr = 2'd0; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;

        check("rst_tx", tx, 1'b1);
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check_status("rst_status");
        reg_read(2'd2, v);
        check("rst_ctrl", v, 8'h00);

        // single frame, start bit length and mid-frame status
        host_ctrl(8'h01);
        host_tx(8'h55);
        wait_tx_low(cyc);
        zeros = 0;
        while (tx === 1'b0 && zeros < 100) begin
            zeros++;
            @(negedge clk);
        end
        check("start_len", zeros, CLKS);
        reg_read(2'd1, v);
        check("status_active", v, 8'h2A);
        wait_tx("single");
        check_status("single_status");

        // overflow while disabled
        host_ctrl(8'h00);
        for (int i = 1; i <= 4; i++) host_tx(8'(i));
        check_status("ovf_full");
        host_tx(8'h05);
        check_status("ovf_after_drop");
        host_ctrl(8'h01);
        wait_tx("ovf");
        check_status("ovf_drained");

        for (int r = 0; r < 3; r++) begin
            host_ctrl(8'h00);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) host_tx(8'($urandom));
            check_status("rtx_status");
            host_ctrl(8'h01);
            wait_tx("rtx");
        end

        // RX overrun
        host_ctrl(8'h01);
        for (int i = 0; i < 5; i++) rx_send(8'hA0 + 8'(i));
        check_status("ovr_status");
        for (int i = 0; i < 4; i++) check_rx_read("ovr_read");
        check_status("ovr_empty");
        host_ctrl(8'h09);
        check_status("ovr_cleared");

        for (int r = 0; r < 3; r++) begin
            host_ctrl({5'b0, 1'($urandom), 1'($urandom), 1'b1});
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) rx_send(8'($urandom));
            check_status("rrx_status");
            check("rrx_irq", irq, exp_irq());
            m = $urandom_range(0, n + 1);
            for (int i = 0; i < m; i++) check_rx_read("rrx_read");
            check_status("rrx_status2");
            check("rrx_irq2", irq, exp_irq());
            for (int i = 0; i < DEPTH + 1; i++) check_rx_read("rrx_drain");
            host_ctrl(8'h09);
        end

        // empty reads, irq, register decode corners
        check_rx_read("empty_read");
        host_ctrl(8'h03);
        check("irq_idle", irq, 1'b0);
        rx_send(8'h3C);
        check("irq_rx", irq, 1'b1);
        check_rx_read("irq_read");
        check("irq_clear", irq, 1'b0);
        host_ctrl(8'h05);
        check("irq_tx", irq, 1'b1);
        reg_read(2'd3, v);
        check("reserved_read", v, 8'h00);
        reg_write(2'd3, 8'hFF);
        reg_write(2'd1, 8'hFF);
        reg_read(2'd2, v);
        check("ctrl_read", v, 8'h05);
        check_status("status_unwritable");
        host_ctrl(8'h01);

        // reset in the middle of data bit 3 of 0xF0
        reg_write(2'd0, 8'hF0);
        wait_tx_low(cyc);
        repeat (4 * CLKS - 1 + CLKS / 2) @(negedge clk);
        check("bit3_low", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx, 1'b1);
        rst = 1'b0;
        txq.delete(); rxq.delete(); ovr_m = 1'b0; ctrl_m = 3'b000;
        check("rst_mid_rdata", rdata, 8'h00);
        check_status("rst_mid_status");
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("no_frame_after_rst", zeros, 0);
        mon_q.delete();

        // loopback
        loopback = 1'b1;
        host_ctrl(8'h01);
        host_tx(8'h00);
        host_tx(8'hFF);
        host_tx(8'h81);
        rxq.push_back(8'h00);
        rxq.push_back(8'hFF);
        rxq.push_back(8'h81);
        wait_tx("loop_tx");
        check_status("loop_status");
        for (int i = 0; i < 3; i++) check_rx_read("loop_read");
        check_status("loop_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL provide parameter MAIN_FREQUENCY, default 100000000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, entries per TX/RX FIFO; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port rx, input, 1, serial receive line, idle high.
REQ-007 SHALL have port tx, output, 1, serial transmit line, idle high.
REQ-008 SHALL have port addr, input, 2, register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-009 SHALL have port wr, input, 1, single-cycle register write strobe.
REQ-010 SHALL have port rd, input, 1, single-cycle register read strobe.
REQ-011 SHALL have port wdata, input, 8, write data.
REQ-012 SHALL have port rdata, output, 8, registered read data.
REQ-013 SHALL have port irq, output, 1, level interrupt: (CTRL.rx_ie and RX not empty) or (CTRL.tx_ie and TX empty).

Function
REQ-014 SHALL return rdata on the cycle after rd; it holds until the next rd. Reserved address reads 0. Writes to STATUS or reserved are ignored.
REQ-015 SHALL map STATUS bits [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_overrun (sticky), [5] tx_active; [7:6] read 0.
REQ-016 SHALL map CTRL bits [0] enable, [1] rx_ie, [2] tx_ie as read/write; CTRL bit [3] is write-1-to-clear rx_overrun and reads 0.
REQ-017 SHALL push wdata into the TX FIFO on wr to DATA. When the TX FIFO is full, SHALL drop the byte and leave the FIFO unchanged.
REQ-018 SHALL pop the RX FIFO on rd to DATA and return the popped byte. When the RX FIFO is empty, SHALL return 0 and leave the FIFO unchanged.
REQ-019 SHALL drive the embedded uart en from CTRL.enable; with enable=0, no new transmission starts and no reception begins.
REQ-020 SHALL run a TX FSM with states IDLE, LOAD and WAIT.
REQ-021 IDLE -> LOAD when enable=1 and the TX FIFO is non-empty. The head byte is presented on uart data_in without popping.
REQ-022 In LOAD, SHALL assert uart we and hold data_in stable until uart tx_busy=1. It then SHALL pop the FIFO and go to WAIT.
REQ-023 In WAIT, SHALL deassert we and go to IDLE on the uart tx_done pulse.
REQ-024 tx_active SHALL be 1 in LOAD and WAIT.
REQ-025 Clearing enable during LOAD or WAIT SHALL NOT abort a frame in progress.
REQ-026 On a uart rx_done pulse, SHALL push uart data_out into the RX FIFO. If the RX FIFO is full, SHALL drop the byte and set rx_overrun.
REQ-027 A simultaneous push and pop SHALL succeed on a full FIFO (count unchanged) and on an empty FIFO only the push applies. The same holds for the TX pop with a DATA write, and for an rx_done push with a DATA read.
REQ-028 FIFO pointers SHALL be log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, with a separate count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 On rst, SHALL reset as follows:
- tx=1, rdata=0, irq=0
- CTRL=0, rx_overrun=0
- both FIFOs empty
- TX FSM in IDLE
- embedded uart reset
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; tx returns high on the next cycle and the byte is lost.

Structure
REQ-031 SHALL place the following in shared package uart_pkg:
- register addresses
- STATUS/CTRL bit positions
- TX FSM state encoding
REQ-032 SHALL instantiate the existing uart block, passing MAIN_FREQUENCY and BAUD, with clk and rst shared.
REQ-033 SHALL implement the FIFOs as one sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice.

Verification
REQ-034 Single TX: enable=1; write 0x55 to DATA -> tx shows start bit, then 1,0,1,0,1,0,1,0 (LSB first), then stop, each bit ~868 clk; tx_empty=1 afterwards.
REQ-035 TX overflow: enable=0; write 0x01..0x05 -> tx_full=1 after 4 writes and 0x05 dropped; set enable -> exactly 0x01..0x04 are sent back-to-back.
REQ-036 RX overrun: drive 5 frames 0xA0..0xA4 on rx with no reads -> rx_full=1 and rx_overrun=1; 4 DATA reads return 0xA0..0xA3, then rx_empty=1; write CTRL bit3 -> overrun=0.
REQ-037 Empty reads and IRQ: read DATA with RX empty -> 0. Set rx_ie, receive 0x3C -> irq=1; read 0x3C -> irq=0. Set tx_ie with TX empty -> irq=1.
REQ-038 Reset mid-frame: assert rst during data bit 3 of 0xF0 -> tx=1 next cycle; STATUS=0x0A (tx_empty, rx_empty); no further frame bits.
REQ-039 Loopback: tie tx to rx; send 0x00, 0xFF, 0x81 -> RX FIFO returns them in order, no overrun.
